// File: rtl/cpu_pkg.sv
// Shared register-file write types and constants for the write-back path.
package cpu_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;
  localparam int NUM_SRC    = 3;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {SRC_ALU, SRC_AUX, SRC_LDR} wb_src_e;

  function automatic logic [NUM_REGS-1:0] reg_dec(input logic [REG_ADDR_W-1:0] a);
    reg_dec    = '0;
    reg_dec[a] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Source handshakes, register-file write port and hazard mask of the write-back arbiter.
interface wb_arbiter_if;
  import cpu_pkg::*;
  logic                  alu_valid, alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0]     alu_data;
  logic                  aux_valid, aux_ready;
  logic [REG_ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0]     aux_data;
  logic                  ldr_valid, ldr_ready;
  logic [REG_ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0]     ldr_data;
  logic                  w_en;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]     w_data;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  idle;

  modport master (
    output alu_valid, alu_addr, alu_data, aux_valid, aux_addr, aux_data,
           ldr_valid, ldr_addr, ldr_data,
    input  alu_ready, aux_ready, ldr_ready, w_en, w_addr, w_data, busy_mask, idle
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, aux_valid, aux_addr, aux_data,
           ldr_valid, ldr_addr, ldr_data,
    output alu_ready, aux_ready, ldr_ready, w_en, w_addr, w_data, busy_mask, idle
  );
endinterface

// File: rtl/wb_fifo.sv
// Per-source write queue; pointers carry one wrap bit so full/empty need no counter.
module wb_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  wb_req_t                              din_i,
  input  logic                                 pop_i,
  output logic                                 full_o,
  output logic                                 empty_o,
  output wb_req_t                              head_o,
  output logic [DEPTH-1:0]                     ent_vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_addr_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, rd_ptr_q, cnt;
  logic [AW-1:0] off;
  wb_req_t       mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign cnt     = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // Slot i holds live data when its distance from the read pointer is below the fill count.
  always_comb begin
    ent_vld_o  = '0;
    ent_addr_o = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = AW'(i) - rd_ptr_q[AW-1:0];
      ent_vld_o[i]  = ({1'b0, off} < cnt);
      ent_addr_o[i] = mem_q[i].addr;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Three-source write-back arbiter: one registered register-file write per cycle, starvation-bounded.
module wb_arbiter import cpu_pkg::*; #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic    [NUM_SRC-1:0]                             vld, rdy, push, pop, full, empty;
  wb_req_t [NUM_SRC-1:0]                             din, head;
  logic    [NUM_SRC-1:0][DEPTH-1:0]                  ent_vld;
  logic    [NUM_SRC-1:0][DEPTH-1:0][REG_ADDR_W-1:0]  ent_addr;
  logic    [NUM_SRC-1:0][CW-1:0]                     starve_q, starve_d;
  logic                                              win_vld, w_en_q;
  wb_src_e                                           win;
  wb_req_t                                           w_q;
  logic    [NUM_REGS-1:0]                            busy;

  assign vld       = {bus.ldr_valid, bus.aux_valid, bus.alu_valid};
  assign din[SRC_ALU] = '{addr: bus.alu_addr, data: bus.alu_data};
  assign din[SRC_AUX] = '{addr: bus.aux_addr, data: bus.aux_data};
  assign din[SRC_LDR] = '{addr: bus.ldr_addr, data: bus.ldr_data};

  // R0 writes complete the handshake but are dropped before the queue.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign rdy[s]  = !full[s];
    assign push[s] = vld[s] && rdy[s] && (din[s].addr != REG_ZERO);
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk, .rst_n,
      .push_i(push[s]), .din_i(din[s]), .pop_i(pop[s]),
      .full_o(full[s]), .empty_o(empty[s]), .head_o(head[s]),
      .ent_vld_o(ent_vld[s]), .ent_addr_o(ent_addr[s])
    );
  end

  // Scan lowest priority first so the highest-priority match is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win     = SRC_ALU;
    for (int s = NUM_SRC - 1; s >= 0; s--)
      if (!empty[s]) begin
        win_vld = 1'b1;
        win     = wb_src_e'(s);
      end
    for (int s = NUM_SRC - 1; s >= 0; s--)
      if (!empty[s] && starve_q[s] == CW'(STARVE_LIMIT)) win = wb_src_e'(s);
  end

  assign pop = win_vld ? (NUM_SRC'(1) << win) : '0;

  always_comb begin
    starve_d = starve_q;
    for (int s = 0; s < NUM_SRC; s++)
      if (empty[s] || win == wb_src_e'(s)) starve_d[s] = '0;
      else if (starve_q[s] != CW'(STARVE_LIMIT)) starve_d[s] = starve_q[s] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_q   <= 1'b0;
      w_q      <= '0;
      starve_q <= '0;
    end else begin
      w_en_q   <= win_vld;
      starve_q <= starve_d;
      if (win_vld) w_q <= head[win];
    end
  end

  always_comb begin
    busy = '0;
    for (int s = 0; s < NUM_SRC; s++)
      for (int e = 0; e < DEPTH; e++)
        if (ent_vld[s][e]) busy = busy | reg_dec(ent_addr[s][e]);
    if (w_en_q) busy = busy | reg_dec(w_q.addr);
    busy[0] = 1'b0;
  end

  assign bus.alu_ready = rdy[SRC_ALU];
  assign bus.aux_ready = rdy[SRC_AUX];
  assign bus.ldr_ready = rdy[SRC_LDR];
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_q.addr;
  assign bus.w_data    = w_q.data;
  assign bus.busy_mask = busy;
  assign bus.idle      = (&empty) && !w_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus starvation, backpressure and reset sequences.
module tb_wb_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        av; logic [3:0] aa; logic [31:0] ad;
    logic        xv; logic [3:0] xa; logic [31:0] xd;
    logic        lv; logic [3:0] la; logic [31:0] ld;
    logic        e_wen; logic [3:0] e_waddr; logic [31:0] e_wdata;
    logic [15:0] e_busy; logic e_idle; logic [2:0] e_rdy;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(
    input logic av, input logic [3:0] aa, input logic [31:0] ad,
    input logic xv, input logic [3:0] xa, input logic [31:0] xd,
    input logic lv, input logic [3:0] la, input logic [31:0] ld,
    input logic wen, input logic [3:0] wa, input logic [31:0] wd,
    input logic [15:0] bm, input logic idl, input logic [2:0] rdy);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.xv = xv; v.xa = xa; v.xd = xd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.e_wen = wen; v.e_waddr = wa; v.e_wdata = wd;
    v.e_busy = bm; v.e_idle = idl; v.e_rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(
    input logic av, input logic [3:0] aa, input logic [31:0] ad,
    input logic xv, input logic [3:0] xa, input logic [31:0] xd,
    input logic lv, input logic [3:0] la, input logic [31:0] ld);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.aux_valid = xv; bus.aux_addr = xa; bus.aux_data = xd;
    bus.ldr_valid = lv; bus.ldr_addr = la; bus.ldr_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdys();
    return {bus.ldr_ready, bus.aux_ready, bus.alu_ready};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic [3:0]  ga[2];
    logic [31:0] gd[2];
    logic done;

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_wen",   bus.w_en, 0);
    chk("rst_waddr", bus.w_addr, 0);
    chk("rst_wdata", bus.w_data, 0);
    chk("rst_busy",  bus.busy_mask, 0);
    chk("rst_idle",  bus.idle, 1);
    chk("rst_rdy",   rdys(), 3'b111);
    @(negedge clk);
    rst_n = 1'b1;

    vt[0] = mk(1, 4'd3, 32'h11, 0, 0, 0, 0, 0, 0,            0, 4'd0, 32'h0,  16'h0008, 0, 3'b111);
    vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    1, 4'd3, 32'h11, 16'h0008, 0, 3'b111);
    vt[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 4'd3, 32'h11, 16'h0000, 1, 3'b111);
    vt[3] = mk(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2, 1, 4'd4, 32'hA4, 0, 4'd3, 32'h11, 16'h0016, 0, 3'b111);
    vt[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    1, 4'd1, 32'hA1, 16'h0016, 0, 3'b111);
    vt[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    1, 4'd2, 32'hA2, 16'h0014, 0, 3'b111);
    vt[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    1, 4'd4, 32'hA4, 16'h0010, 0, 3'b111);
    vt[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 4'd4, 32'hA4, 16'h0000, 1, 3'b111);
    vt[8] = mk(0, 0, 0, 0, 0, 0, 1, 4'd0, 32'hDEAD,          0, 4'd4, 32'hA4, 16'h0000, 1, 3'b111);
    vt[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 4'd4, 32'hA4, 16'h0000, 1, 3'b111);

    foreach (vt[i]) begin
      set_in(vt[i].av, vt[i].aa, vt[i].ad, vt[i].xv, vt[i].xa, vt[i].xd,
             vt[i].lv, vt[i].la, vt[i].ld);
      if (vt[i].lv) chk($sformatf("v%0d_ldr_ready_pre", i), bus.ldr_ready, 1);
      tick();
      chk($sformatf("v%0d_wen", i),   bus.w_en,      vt[i].e_wen);
      chk($sformatf("v%0d_waddr", i), bus.w_addr,    vt[i].e_waddr);
      chk($sformatf("v%0d_wdata", i), bus.w_data,    vt[i].e_wdata);
      chk($sformatf("v%0d_busy", i),  bus.busy_mask, vt[i].e_busy);
      chk($sformatf("v%0d_idle", i),  bus.idle,      vt[i].e_idle);
      chk($sformatf("v%0d_rdy", i),   rdys(),        vt[i].e_rdy);
    end

    // Starvation: ALU streams R6, a single LDR entry R5 must win on the 5th arbitration.
    for (int k = 1; k <= 6; k++) begin
      set_in(1, 4'd6, 32'h600 + k, 0, 0, 0, k == 1, 4'd5, 32'h55);
      tick();
      if (k >= 2) begin
        chk($sformatf("stv%0d_wen", k),   bus.w_en, 1);
        chk($sformatf("stv%0d_waddr", k), bus.w_addr, (k == 6) ? 32'd5 : 32'd6);
        chk($sformatf("stv%0d_wdata", k), bus.w_data, (k == 6) ? 32'h55 : 32'h600 + k - 1);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stv7_waddr", bus.w_addr, 6);
    chk("stv7_wdata", bus.w_data, 32'h605);
    tick();
    chk("stv8_wdata", bus.w_data, 32'h606);
    tick();
    chk("stv9_wen",  bus.w_en, 0);
    chk("stv9_idle", bus.idle, 1);

    // Backpressure: AUX fills behind ALU traffic; third entry waits for a pop.
    for (int k = 1; k <= 7; k++) begin
      set_in(1, 4'd7, 32'h700,
             1, (k == 1) ? 4'd8 : (k == 2) ? 4'd9 : 4'd10,
             (k == 1) ? 32'h81 : (k == 2) ? 32'h82 : 32'h83,
             0, 0, 0);
      tick();
      if (k >= 2 && k <= 5) begin
        chk($sformatf("bp%0d_aux_ready", k), bus.aux_ready, 0);
        chk($sformatf("bp%0d_busy10", k),    bus.busy_mask[10], 0);
      end
      if (k == 6) begin
        chk("bp6_waddr",     bus.w_addr, 8);
        chk("bp6_wdata",     bus.w_data, 32'h81);
        chk("bp6_aux_ready", bus.aux_ready, 1);
        chk("bp6_busy10",    bus.busy_mask[10], 0);
      end
      if (k == 7) begin
        chk("bp7_busy10",    bus.busy_mask[10], 1);
        chk("bp7_aux_ready", bus.aux_ready, 0);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nw = 0;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (bus.w_en && bus.w_addr != 4'd7) begin
        if (nw < 2) begin
          ga[nw] = bus.w_addr;
          gd[nw] = bus.w_data;
        end
        nw++;
      end
      if (bus.idle) done = 1'b1;
    end
    chk("bp_drain_idle", done, 1);
    chk("bp_aux_writes", nw, 2);
    if (nw >= 2) begin
      chk("bp_aux0_addr", ga[0], 9);
      chk("bp_aux0_data", gd[0], 32'h82);
      chk("bp_aux1_addr", ga[1], 10);
      chk("bp_aux1_data", gd[1], 32'h83);
    end

    // Mid-cycle reset with three queued entries and a write in flight.
    set_in(1, 4'd1, 32'hB1, 1, 4'd2, 32'hB2, 1, 4'd4, 32'hB4);
    tick();
    set_in(1, 4'd3, 32'hB3, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mr_pre_wen",  bus.w_en, 1);
    chk("mr_pre_busy", bus.busy_mask, 16'h001E);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_wen",  bus.w_en, 0);
    chk("mr_busy", bus.busy_mask, 0);
    chk("mr_rdy",  rdys(), 3'b111);
    chk("mr_idle", bus.idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mr_post%0d_wen", c), bus.w_en, 0);
      chk($sformatf("mr_post%0d_idle", c), bus.idle, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
